// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the single-clock FIFO buffer.
//   fifo_depth       : number of words for a given address width
//   fifo_ptrw        : pointer width (one extra wrap bit over the address)
//   ptr_count        : occupancy from write/read pointers, modulo 2^ptrw
//   thresholds_legal : elaboration-time sanity check of the flag thresholds
// ---------------------------------------------------------------------------
package fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic int unsigned fifo_ptrw(input int unsigned addrsize);
    return addrsize + 32'd1;
  endfunction

  // The pointers carry one wrap bit, so their difference taken modulo
  // 2^ptrw is the occupancy even after either pointer has rolled over.
  function automatic logic [31:0] ptr_count(input logic [31:0] wp,
                                            input logic [31:0] rp,
                                            input int unsigned ptrw);
    logic [31:0] mask;
    mask = (32'd1 << ptrw) - 32'd1;
    return (wp - rp) & mask;
  endfunction

  function automatic bit thresholds_legal(input int unsigned aempty,
                                          input int unsigned afull,
                                          input int unsigned depth);
    return (aempty < afull) && (afull <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// DEPTH x DATASIZE storage array: one synchronous write port and one
// combinational read port. Contents are never reset.
//   clk    : clock, rising edge
//   w_en   : write strobe (already qualified by the caller)
//   w_addr : write address
//   w_data : write data
//   r_addr : read address
//   r_data : mem[r_addr], combinational
// ---------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                w_en,
  input  logic [ADDRSIZE-1:0] w_addr,
  input  logic [DATASIZE-1:0] w_data,
  input  logic [ADDRSIZE-1:0] r_addr,
  output logic [DATASIZE-1:0] r_data
);

  logic [DATASIZE-1:0] mem [2**ADDRSIZE];

  // Storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_buf.sv
// ---------------------------------------------------------------------------
// sync_fifo_buf
// Single-clock FIFO with occupancy count, full/empty and programmable
// almost-full/almost-empty flags, synchronous flush, overflow/underflow
// pulses and an optional registered read port.
//   clk, rst        : clock (rising edge), async active-high reset
//   flush           : synchronous clear of pointers and pulses
//   w_en, w_data    : write request and data
//   r_en            : read request
//   r_data, r_valid : read data; r_valid only meaningful when OUTREG=1
//   w_full, r_empty : count == DEPTH / count == 0
//   w_almost_full   : count >= AFULL_THRESH
//   r_almost_empty  : count <= AEMPTY_THRESH
//   count           : occupancy 0..DEPTH
//   overflow        : one-cycle pulse after a write attempted while full
//   underflow       : one-cycle pulse after a read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE      = 8,
  parameter int unsigned ADDRSIZE      = 4,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned OUTREG        = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                w_en,
  input  logic [DATASIZE-1:0] w_data,
  input  logic                r_en,
  output logic [DATASIZE-1:0] r_data,
  output logic                r_valid,
  output logic                w_full,
  output logic                r_empty,
  output logic                w_almost_full,
  output logic                r_almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDRSIZE);
  localparam int unsigned PTRW  = fifo_ptrw(ADDRSIZE);

  localparam logic [PTRW-1:0] FULL_CNT   = PTRW'(DEPTH);
  localparam logic [PTRW-1:0] AFULL_CNT  = PTRW'(AFULL_THRESH);
  localparam logic [PTRW-1:0] AEMPTY_CNT = PTRW'(AEMPTY_THRESH);

  if (!thresholds_legal(AEMPTY_THRESH, AFULL_THRESH, DEPTH)) begin : g_bad_params
    $error("sync_fifo_buf: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [PTRW-1:0]     w_ptr;
  logic [PTRW-1:0]     r_ptr;
  logic [DATASIZE-1:0] ram_rdata;
  logic                w_accept;
  logic                r_accept;

  // Flags come straight from the pointer registers, so they reflect an
  // operation only after the edge that performed it.
  assign count          = PTRW'(ptr_count(32'(w_ptr), 32'(r_ptr), PTRW));
  assign w_full         = (count == FULL_CNT);
  assign r_empty        = (count == '0);
  assign w_almost_full  = (count >= AFULL_CNT);
  assign r_almost_empty = (count <= AEMPTY_CNT);

  // Flush outranks both requests, so it also blocks the memory write.
  assign w_accept = w_en & ~w_full & ~flush;
  assign r_accept = r_en & ~r_empty & ~flush;

  sync_fifo_ram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk    (clk),
    .w_en   (w_accept),
    .w_addr (w_ptr[ADDRSIZE-1:0]),
    .w_data (w_data),
    .r_addr (r_ptr[ADDRSIZE-1:0]),
    .r_data (ram_rdata)
  );

  // Pointer advance and error pulses. The pulses are judged on the flags
  // as they stood before the edge, matching the accept decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_accept) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (r_accept) begin
        r_ptr <= r_ptr + 1'b1;
      end
      overflow  <= w_en & w_full;
      underflow <= r_en & r_empty;
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic [DATASIZE-1:0] r_data_q;
    logic                r_valid_q;

    // Registered read port: capture the head word on an accepted read;
    // r_data holds between reads and across a flush.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else if (flush) begin
        r_valid_q <= 1'b0;
      end else if (r_accept) begin
        r_data_q  <= ram_rdata;
        r_valid_q <= 1'b1;
      end else begin
        r_valid_q <= 1'b0;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end else begin : g_showahead
    assign r_data  = ram_rdata;
    assign r_valid = 1'b0;
  end

endmodule
